// File: rtl/req_code_if.sv
// Request/code handshake bundle between the request sources, the scheduler
// and the one-code-at-a-time consumer.
interface req_code_if;
  logic [7:0] req_i;
  logic       out_ready_i;
  logic       out_valid_o;
  logic [3:0] code_o;
  logic [2:0] idx_o;
  logic       busy_o;
  logic [7:0] grant_cnt_o;

  modport master (
    input  req_i, out_ready_i,
    output out_valid_o, code_o, idx_o, busy_o, grant_cnt_o
  );

  modport slave (
    output req_i, out_ready_i,
    input  out_valid_o, code_o, idx_o, busy_o, grant_cnt_o
  );
endinterface

// File: rtl/req_code_scheduler.sv
// Shares the 8-to-4 priority code table among 8 requesters: sticky pending
// capture, one grant at a time over valid/ready, fixed dwell after each accept.
module req_code_scheduler #(
  parameter bit          RR_EN       = 1'b1,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  req_code_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] pend;
  logic [7:0] clr;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;
  logic [2:0] pick;
  logic [2:0] scan;
  logic       found;
  logic       accept;

  // Table lookup: requester index -> 4-bit code.
  function automatic logic [3:0] code_of(input logic [2:0] i);
    case (i)
      3'd7:    code_of = 4'b0000;
      3'd6:    code_of = 4'b0100;
      3'd5:    code_of = 4'b0001;
      3'd4:    code_of = 4'b0101;
      3'd3:    code_of = 4'b0011;
      3'd2:    code_of = 4'b0111;
      3'd1:    code_of = 4'b0010;
      default: code_of = 4'b0110;
    endcase
  endfunction

  assign accept = bus.out_valid_o & bus.out_ready_i;
  assign clr    = accept ? (8'b1 << bus.idx_o) : 8'b0;
  assign bus.busy_o = (state != IDLE);

  // Arbiter: scan downward from ptr (rotating) or from bit 7 (fixed).
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    scan  = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan = RR_EN ? (ptr - 3'(k)) : (3'd7 - 3'(k));
      if (!found && pend[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: grant when anything is pending, dwell after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend) state_nxt = SEND;
      SEND:    if (accept) state_nxt = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      HOLD:    if (hold_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: pending capture (set wins over clear), output registers,
  // rotation pointer, dwell counter and grant counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend            <= 8'd0;
      ptr             <= 3'd7;
      hold_cnt        <= 8'd0;
      bus.out_valid_o <= 1'b0;
      bus.code_o      <= 4'd0;
      bus.idx_o       <= 3'd0;
      bus.grant_cnt_o <= 8'd0;
    end else begin
      pend <= (pend & ~clr) | bus.req_i;
      if (state == IDLE && |pend) begin
        bus.out_valid_o <= 1'b1;
        bus.idx_o       <= pick;
        bus.code_o      <= code_of(pick);
      end
      if (accept) begin
        bus.out_valid_o <= 1'b0;
        bus.grant_cnt_o <= bus.grant_cnt_o + 8'd1;
        hold_cnt        <= HOLD_LOAD;
        if (RR_EN) ptr <= bus.idx_o - 3'd1;
      end else if (state == HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_req_code_scheduler.sv
// Drives two scheduler configurations (rotating/dwell 4 and fixed/no dwell)
// with shared stimulus; a reference model per instance predicts each grant.
module tb_req_code_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic       ready = 1'b0;
  logic [1:0] vmon;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] CTAB [0:7] = '{4'b0110, 4'b0010, 4'b0111, 4'b0011,
                                       4'b0101, 4'b0001, 4'b0100, 4'b0000};

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic [3:0] code;
  } exp_t;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam bit RR   = (g == 0);
    localparam int HOLD = (g == 0) ? 4 : 0;

    req_code_if bus ();
    assign bus.req_i       = req;
    assign bus.out_ready_i = ready;
    assign vmon[g]         = bus.out_valid_o;

    req_code_scheduler #(.RR_EN(RR), .HOLD_CYCLES(HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Reference model state: pending set, current offer, earliest grant edge.
    exp_t       expq[$];
    logic [7:0] m_pend;
    logic [2:0] m_ptr;
    logic [2:0] m_idx;
    logic       m_valid;
    logic [7:0] m_cnt;
    int         m_cyc = 0;
    int         free_at;
    logic [7:0] m_clr;
    logic [2:0] s;
    bit         got;
    bit         prev_v;
    logic [2:0] lat_idx;
    logic [3:0] lat_code;
    exp_t       e;

    // Model: one step per clock edge.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_pend = 0; m_ptr = 7; m_idx = 0; m_valid = 0; m_cnt = 0; free_at = 0;
        expq.delete();
      end else begin
        m_cyc++;
        m_clr = 0;
        if (m_valid && ready) begin
          m_clr   = 8'b1 << m_idx;
          m_valid = 0;
          m_cnt   = m_cnt + 8'd1;
          if (RR) m_ptr = 3'((int'(m_idx) + 7) % 8);
          free_at = m_cyc + HOLD + 1;
        end else if (!m_valid && m_cyc >= free_at && m_pend != 0) begin
          got = 0;
          for (int k = 0; k < 8; k++) begin
            s = RR ? 3'((int'(m_ptr) - k + 8) % 8) : 3'(7 - k);
            if (!got && m_pend[s]) begin got = 1; m_idx = s; end
          end
          m_valid = 1;
          expq.push_back('{m_cyc, m_idx, CTAB[m_idx]});
        end
        m_pend = (m_pend & ~m_clr) | req;
      end
    end

    // Monitor: per-cycle status checks plus scoreboard pop on each new offer.
    always @(negedge clk) begin
      chk($sformatf("cfg%0d valid", g), int'(bus.out_valid_o), int'(m_valid));
      chk($sformatf("cfg%0d grant_cnt", g), int'(bus.grant_cnt_o), int'(m_cnt));
      if (rst) begin
        chk($sformatf("cfg%0d rst idx", g), int'(bus.idx_o), 0);
        chk($sformatf("cfg%0d rst code", g), int'(bus.code_o), 0);
        chk($sformatf("cfg%0d rst busy", g), int'(bus.busy_o), 0);
        prev_v = 0;
      end else begin
        chk($sformatf("cfg%0d busy", g), int'(bus.busy_o),
            int'(m_valid || (m_cyc < free_at - 1)));
        if (bus.out_valid_o && !prev_v) begin
          if (expq.size() == 0) begin
            chk($sformatf("cfg%0d unexpected grant", g), 1, 0);
          end else begin
            e = expq.pop_front();
            chk($sformatf("cfg%0d idx", g), int'(bus.idx_o), int'(e.idx));
            chk($sformatf("cfg%0d code", g), int'(bus.code_o), int'(e.code));
            chk($sformatf("cfg%0d grant edge", g), m_cyc, e.cyc);
          end
          lat_idx  = bus.idx_o;
          lat_code = bus.code_o;
        end else if (bus.out_valid_o) begin
          chk($sformatf("cfg%0d idx stable", g), int'(bus.idx_o), int'(lat_idx));
          chk($sformatf("cfg%0d code stable", g), int'(bus.code_o), int'(lat_code));
        end
        prev_v = bus.out_valid_o;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    @(posedge clk); #1 req = v;
    @(posedge clk); #1 req = 8'd0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!vmon[0] && n < 50) begin step(1); n++; end
    chk("wait for valid", int'(vmon[0]), 1);
  endtask

  initial begin
    step(3);
    rst = 1'b0;

    // Reset while a grant is being offered.
    ready = 1'b0;
    pulse(8'h40);
    wait_valid();
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    // Held all-request stream, rotation and wrap of the pointer.
    ready = 1'b1;
    req   = 8'hFF;
    step(60);
    req = 8'h00;
    step(20);

    // Two requests in one pulse.
    pulse(8'h81);
    step(20);

    // Backpressure with a higher request arriving mid-offer.
    ready = 1'b0;
    pulse(8'h04);
    step(10);
    pulse(8'h80);
    step(5);
    ready = 1'b1;
    step(30);

    // Re-request on the accept cycle: set wins over clear.
    ready = 1'b0;
    pulse(8'h08);
    wait_valid();
    ready = 1'b1;
    req   = 8'h08;
    step(1);
    req = 8'h00;
    step(20);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      req   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req = 8'h00;
    ready = 1'b1;
    step(20);

    // Long saturated run so both grant counters wrap.
    req = 8'hFF;
    step(1700);
    req = 8'h00;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
